// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-pixel packer: word width, FSM
// state encoding and the words-per-row helper.
package edge_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        PACK,
        DRAIN
    } state_t;

    function automatic int words_per_row(input int px_per_row);
        return (px_per_row + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry synchronous FIFO built as a head/tail register pair, so the head
// entry always comes straight from a flop.
module word_fifo2 #(
    parameter int DATA_W = 46
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count;
    logic              do_pop;
    logic              do_push;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = head_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still taken when a pop frees the head slot.
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage is reset as well because head_q drives the output
    // port directly and must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments let head_q take the old tail_q
            // while tail_q loads the new word in the same edge.
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty) head_q <= din;
                    else       tail_q <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/edge_px_packer.sv
// Packs the 1-bit Sobel edge stream LSB-first into 32-bit words, row-padded,
// and writes them to frame memory through a 2-entry valid/ready queue.
module edge_px_packer
    import edge_pkg::*;
#(
    parameter logic [15:0] px_per_row     = 16'd520,
    parameter logic [15:0] rows_per_frame = 16'd400,
    parameter logic [15:0] lead_px        = 16'd1043,
    parameter int          ADDR_W         = 14
) (
    input  logic              CLK100MHZ,
    input  logic              btn_reset,
    input  logic              frame_start,
    input  logic              ena,
    input  logic              px_in,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_din,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int ENTRY_W = ADDR_W + WORD_W;

    state_t              state;
    state_t              state_nx;
    logic [15:0]         skip_cnt;
    logic [15:0]         col;
    logic [15:0]         row;
    logic [4:0]          bit_cnt;
    logic [ADDR_W-1:0]   word_addr;
    logic [WORD_W-1:0]   shift_word;
    logic [WORD_W-1:0]   cur_word;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                word_done;
    logic                row_end;
    logic                frame_end;
    logic                last_pop;

    assign pop                 = !fifo_empty && mem_ready;
    assign mem_valid           = !fifo_empty;
    assign {mem_addr, mem_din} = head;
    assign busy                = (state != IDLE);

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nx          = state;
        push              = 1'b0;
        last_pop          = 1'b0;
        cur_word          = shift_word;
        cur_word[bit_cnt] = px_in;
        row_end           = (col == px_per_row - 16'd1);
        word_done         = (bit_cnt == 5'd31) || row_end;
        frame_end         = row_end && (row == rows_per_frame - 16'd1);

        if (frame_start) begin
            state_nx = (lead_px == 16'd0) ? PACK : SKIP;
        end else begin
            case (state)
                IDLE: ;
                SKIP: if (ena && skip_cnt == lead_px - 16'd1) state_nx = PACK;
                PACK: begin
                    if (ena) begin
                        push = word_done;
                        if (frame_end) state_nx = DRAIN;
                    end
                end
                DRAIN: begin
                    // Nothing is pushed here, so a pop of a non-full queue empties it.
                    last_pop = pop && !fifo_full;
                    if (last_pop) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge btn_reset) begin
        if (!btn_reset) begin
            state      <= IDLE;
            skip_cnt   <= 16'd0;
            col        <= 16'd0;
            row        <= 16'd0;
            bit_cnt    <= 5'd0;
            word_addr  <= '0;
            shift_word <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= last_pop;
            if (frame_start) begin
                skip_cnt   <= 16'd0;
                col        <= 16'd0;
                row        <= 16'd0;
                bit_cnt    <= 5'd0;
                word_addr  <= '0;
                shift_word <= '0;
                overflow   <= 1'b0;
            end else begin
                if (state == SKIP && ena) skip_cnt <= skip_cnt + 16'd1;
                if (state == PACK && ena) begin
                    if (word_done) begin
                        shift_word <= '0;
                        bit_cnt    <= 5'd0;
                        // Dropped words still consume an address to keep later ones positional.
                        word_addr  <= word_addr + ADDR_W'(1);
                        if (fifo_full && !pop) overflow <= 1'b1;
                    end else begin
                        shift_word <= cur_word;
                        bit_cnt    <= bit_cnt + 5'd1;
                    end
                    if (row_end) begin
                        col <= 16'd0;
                        row <= row + 16'd1;
                    end else begin
                        col <= col + 16'd1;
                    end
                end
            end
        end
    end

    word_fifo2 #(
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk   (CLK100MHZ),
        .rst_n (btn_reset),
        .flush (frame_start),
        .push  (push),
        .pop   (pop),
        .din   ({word_addr, cur_word}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_edge_px_packer.sv
// Directed bench: a small 40x2 instance for handshake/abort/reset scenarios
// and a 520-pixel-row instance for row padding.
module tb_edge_px_packer;

    logic        clk = 1'b0;
    logic        btn_reset;
    always #5 clk = ~clk;

    logic        s_fs, s_ena, s_px, s_ready;
    logic        s_valid, s_busy, s_done, s_ovf;
    logic [13:0] s_addr;
    logic [31:0] s_din;

    logic        b_fs, b_ena, b_px, b_ready;
    logic        b_valid, b_busy, b_done, b_ovf;
    logic [13:0] b_addr;
    logic [31:0] b_din;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [13:0] s_acc_addr[$];
    logic [31:0] s_acc_data[$];
    int          s_last_acc, s_done_cnt, s_done_cyc;
    logic        s_stalled = 1'b0;
    logic [45:0] s_held;
    logic [13:0] b_acc_addr[$];
    logic [31:0] b_acc_data[$];
    int          b_done_cnt;

    edge_px_packer #(
        .px_per_row     (16'd40),
        .rows_per_frame (16'd2),
        .lead_px        (16'd3),
        .ADDR_W         (14)
    ) u_small (
        .CLK100MHZ   (clk),
        .btn_reset   (btn_reset),
        .frame_start (s_fs),
        .ena         (s_ena),
        .px_in       (s_px),
        .mem_valid   (s_valid),
        .mem_ready   (s_ready),
        .mem_addr    (s_addr),
        .mem_din     (s_din),
        .busy        (s_busy),
        .frame_done  (s_done),
        .overflow    (s_ovf)
    );

    edge_px_packer #(
        .rows_per_frame (16'd4)
    ) u_big (
        .CLK100MHZ   (clk),
        .btn_reset   (btn_reset),
        .frame_start (b_fs),
        .ena         (b_ena),
        .px_in       (b_px),
        .mem_valid   (b_valid),
        .mem_ready   (b_ready),
        .mem_addr    (b_addr),
        .mem_din     (b_din),
        .busy        (b_busy),
        .frame_done  (b_done),
        .overflow    (b_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitors: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (s_valid && s_ready) begin
            s_acc_addr.push_back(s_addr);
            s_acc_data.push_back(s_din);
            s_last_acc = cyc;
        end
        if (s_done) begin
            s_done_cnt++;
            s_done_cyc = cyc;
        end
        if (s_valid && !s_ready && s_stalled) begin
            n_cmp++;
            if ({s_addr, s_din} !== s_held) begin
                n_err++;
                $display("FAIL stall_hold got %h want %h", {s_addr, s_din}, s_held);
            end
        end
        s_stalled = s_valid && !s_ready;
        s_held    = {s_addr, s_din};
        if (b_valid && b_ready) begin
            b_acc_addr.push_back(b_addr);
            b_acc_data.push_back(b_din);
        end
        if (b_done) b_done_cnt++;
    end

    // Stream pixel: 3 lead pixels set to 1, then px = column parity.
    function automatic logic px_of(input int k);
        if (k < 3) return 1'b1;
        return 1'(((k - 3) % 40) & 1);
    endfunction

    function automatic logic [31:0] small_word(input int a);
        return (a % 2 == 0) ? 32'hAAAA_AAAA : 32'h0000_00AA;
    endfunction

    // All tasks start and end at posedge+1.
    task automatic stream(input int k_from, input int k_to, input int release_k);
        for (int k = k_from; k <= k_to; k++) begin
            if (k == release_k) s_ready = 1'b1;
            s_ena = 1'b1;
            s_px  = px_of(k);
            @(posedge clk); #1;
        end
        s_ena = 1'b0;
    endtask

    task automatic pulse_fs();
        s_fs = 1'b1;
        @(posedge clk); #1;
        s_fs = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (s_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL %s timeout busy got %0b want 0", name, s_busy);
        end
    endtask

    task automatic clear_mon();
        s_acc_addr.delete();
        s_acc_data.delete();
        s_done_cnt = 0;
        s_done_cyc = -1;
        s_last_acc = -1;
    endtask

    task automatic test_reset();
        btn_reset = 1'b0;
        s_fs = 0; s_ena = 0; s_px = 0; s_ready = 1;
        b_fs = 0; b_ena = 0; b_px = 0; b_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({s_valid, s_addr, s_din, s_busy, s_done, s_ovf} !== 49'd0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%0b a=%0d d=%h b=%0b fd=%0b o=%0b want all 0",
                     s_valid, s_addr, s_din, s_busy, s_done, s_ovf);
        end
        btn_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        clear_mon();
        s_ready = 1'b1;
        pulse_fs();
        stream(0, 82, -1);
        wait_idle("basic");
        n_cmp++;
        if (s_acc_addr.size() != 4) begin
            n_err++;
            $display("FAIL basic_count got %0d want 4", s_acc_addr.size());
        end
        for (int i = 0; i < 4 && i < s_acc_addr.size(); i++) begin
            n_cmp++;
            if (s_acc_addr[i] !== 14'(i) || s_acc_data[i] !== small_word(i)) begin
                n_err++;
                $display("FAIL basic_write%0d got %0d/%h want %0d/%h", i,
                         s_acc_addr[i], s_acc_data[i], i, small_word(i));
            end
        end
        n_cmp++;
        if (s_done_cnt != 1 || s_done_cyc != s_last_acc + 1) begin
            n_err++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                     s_done_cnt, s_done_cyc, s_last_acc + 1);
        end
    endtask

    task automatic test_overflow();
        int exp_a[3];
        exp_a = '{0, 1, 3};
        clear_mon();
        s_ready = 1'b0;
        pulse_fs();
        stream(0, 75, -1);
        n_cmp++;
        if (s_valid !== 1'b1 || s_addr !== 14'd0 || s_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_stalled got v=%0b a=%0d o=%0b want v=1 a=0 o=1", s_valid, s_addr, s_ovf);
        end
        stream(76, 82, 76);
        wait_idle("overflow");
        n_cmp++;
        if (s_acc_addr.size() != 3) begin
            n_err++;
            $display("FAIL ovf_count got %0d want 3", s_acc_addr.size());
        end
        for (int i = 0; i < 3 && i < s_acc_addr.size(); i++) begin
            n_cmp++;
            if (s_acc_addr[i] !== 14'(exp_a[i]) || s_acc_data[i] !== small_word(exp_a[i])) begin
                n_err++;
                $display("FAIL ovf_write%0d got %0d/%h want %0d/%h", i,
                         s_acc_addr[i], s_acc_data[i], exp_a[i], small_word(exp_a[i]));
            end
        end
        n_cmp++;
        if (s_ovf !== 1'b1 || s_done_cnt != 1 || s_done_cyc != s_last_acc + 1) begin
            n_err++;
            $display("FAIL ovf_end got o=%0b cnt=%0d cyc=%0d want o=1 cnt=1 cyc=%0d",
                     s_ovf, s_done_cnt, s_done_cyc, s_last_acc + 1);
        end
    endtask

    task automatic test_full_push_pop();
        clear_mon();
        s_ready = 1'b0;
        pulse_fs();
        stream(0, 82, 74);
        wait_idle("fullpp");
        n_cmp++;
        if (s_ovf !== 1'b0 || s_acc_addr.size() != 4) begin
            n_err++;
            $display("FAIL fullpp_summary got o=%0b n=%0d want o=0 n=4", s_ovf, s_acc_addr.size());
        end
        for (int i = 0; i < 4 && i < s_acc_addr.size(); i++) begin
            n_cmp++;
            if (s_acc_addr[i] !== 14'(i) || s_acc_data[i] !== small_word(i)) begin
                n_err++;
                $display("FAIL fullpp_write%0d got %0d/%h want %0d/%h", i,
                         s_acc_addr[i], s_acc_data[i], i, small_word(i));
            end
        end
    endtask

    task automatic test_abort();
        clear_mon();
        s_ready = 1'b1;
        pulse_fs();
        stream(0, 45, -1);
        s_ready = 1'b0;
        stream(46, 74, -1);
        n_cmp++;
        if (s_acc_addr.size() != 2 || s_valid !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre got n=%0d v=%0b want n=2 v=1", s_acc_addr.size(), s_valid);
        end
        pulse_fs();
        n_cmp++;
        if (s_valid !== 1'b0 || s_ovf !== 1'b0 || s_busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_flush got v=%0b o=%0b b=%0b want v=0 o=0 b=1", s_valid, s_ovf, s_busy);
        end
        clear_mon();
        s_ready = 1'b1;
        stream(0, 82, -1);
        wait_idle("abort");
        n_cmp++;
        if (s_acc_addr.size() != 4 || s_done_cnt != 1) begin
            n_err++;
            $display("FAIL abort_refr got n=%0d done=%0d want n=4 done=1", s_acc_addr.size(), s_done_cnt);
        end
        for (int i = 0; i < 4 && i < s_acc_addr.size(); i++) begin
            n_cmp++;
            if (s_acc_addr[i] !== 14'(i) || s_acc_data[i] !== small_word(i)) begin
                n_err++;
                $display("FAIL abort_write%0d got %0d/%h want %0d/%h", i,
                         s_acc_addr[i], s_acc_data[i], i, small_word(i));
            end
        end
    endtask

    task automatic test_async_reset();
        clear_mon();
        s_ready = 1'b0;
        pulse_fs();
        stream(0, 78, -1);
        n_cmp++;
        if (s_valid !== 1'b1 || s_ovf !== 1'b1 || s_busy !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre got v=%0b o=%0b b=%0b want 1 1 1", s_valid, s_ovf, s_busy);
        end
        #3 btn_reset = 1'b0;
        #1;
        n_cmp++;
        if ({s_valid, s_addr, s_din, s_busy, s_done, s_ovf} !== 49'd0) begin
            n_err++;
            $display("FAIL areset_outputs got v=%0b a=%0d d=%h b=%0b fd=%0b o=%0b want all 0",
                     s_valid, s_addr, s_din, s_busy, s_done, s_ovf);
        end
        #2 btn_reset = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        s_ready = 1'b1;
        stream(0, 40, -1);
        n_cmp++;
        if (s_busy !== 1'b0 || s_acc_addr.size() != 0) begin
            n_err++;
            $display("FAIL areset_ignore got b=%0b n=%0d want b=0 n=0", s_busy, s_acc_addr.size());
        end
        pulse_fs();
        stream(0, 82, -1);
        wait_idle("areset");
        n_cmp++;
        if (s_acc_addr.size() != 4 || s_acc_addr[0] !== 14'd0 || s_acc_data[0] !== 32'hAAAA_AAAA) begin
            n_err++;
            $display("FAIL areset_refr got n=%0d first=%0d want n=4 first=0", s_acc_addr.size(),
                     (s_acc_addr.size() > 0) ? int'(s_acc_addr[0]) : -1);
        end
    endtask

    task automatic test_default_row();
        int n;
        int bad;
        logic [31:0] want;
        b_acc_addr.delete();
        b_acc_data.delete();
        b_done_cnt = 0;
        b_ready = 1'b1;
        b_fs = 1'b1;
        @(posedge clk); #1;
        b_fs = 1'b0;
        for (int k = 0; k < 1043 + 4 * 520; k++) begin
            b_ena = 1'b1;
            b_px  = (k >= 1043);
            @(posedge clk); #1;
        end
        b_ena = 1'b0;
        n = 0;
        while (b_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (n >= 200 || b_acc_addr.size() != 68 || b_done_cnt != 1) begin
            n_err++;
            $display("FAIL big_count got n=%0d done=%0d want n=68 done=1", b_acc_addr.size(), b_done_cnt);
        end
        bad = 0;
        for (int i = 0; i < b_acc_addr.size(); i++) begin
            want = (i % 17 == 16) ? 32'h0000_00FF : 32'hFFFF_FFFF;
            n_cmp++;
            if ((b_acc_addr[i] !== 14'(i) || b_acc_data[i] !== want)) begin
                n_err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL big_write%0d got %0d/%h want %0d/%h", i,
                             b_acc_addr[i], b_acc_data[i], i, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_async_reset();
        test_default_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_px_packer.md
Name: edge_px_packer

Overview:
- Sits at the output end of the edge-detection pipeline and consumes the 1-bit pixel stream produced by Sobel_Filter under the shared `ena` strobe.
- Discards the filter's start-up latency pixels, then packs valid edge pixels LSB-first into 32-bit words.
- Each row is padded to a whole number of words.
- Words go to a frame memory over a valid/ready write port, and the block flags frame completion and overflow.

Parameters:
px_per_row, 16'd520, pixels per image row (matches the filter's row length)
rows_per_frame, 16'd400, rows written per frame
lead_px, 16'd1043, `ena` pulses discarded after arm (filter latency, 2*px_per_row+3)
ADDR_W, 14, word address width

Ports:
CLK100MHZ  in  1  system clock
btn_reset  in  1  asynchronous, active-low reset
frame_start  in  1  single-cycle pulse: arm/restart a frame capture
ena  in  1  pixel strobe, same signal that enables the filter
px_in  in  1  binary edge pixel (filter output_px)
mem_valid  out  1  write word available
mem_ready  in  1  memory accepts word this cycle
mem_addr  out  ADDR_W  word address
mem_din  out  32  packed pixel word, bit0 = leftmost pixel
busy  out  1  high in SKIP/PACK/DRAIN
frame_done  out  1  one-cycle pulse when last word of frame is accepted
overflow  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (btn_reset low, asynchronous): state IDLE; all counters 0; FIFO empty.
  - Outputs at reset: mem_valid=0, mem_addr=0, mem_din=0, busy=0, frame_done=0, overflow=0.
- Derived constant: words_per_row = ceil(px_per_row/32). The default gives 17.
- State machine:
  - IDLE: ignore `ena`. On frame_start: clear skip_cnt, col, row, bit_cnt, word_addr and overflow; go to SKIP.
  - SKIP: each `ena` increments skip_cnt. When the pulse that brings the count to lead_px arrives, go to PACK. That pulse's pixel is discarded. If lead_px=0, go straight to PACK the cycle after arm.
  - PACK: each `ena` writes px_in into shift word bit[bit_cnt], then increments bit_cnt and col.
    - A word completes when bit_cnt=31 or col=px_per_row-1. Unfilled upper bits are 0.
    - On completion: push {word_addr, word} into the FIFO, increment word_addr, reset bit_cnt.
    - At end of row: reset col and increment row.
    - After the last pixel of row rows_per_frame-1: go to DRAIN.
  - DRAIN: ignore `ena`. When the FIFO becomes empty by a pop, pulse frame_done for 1 cycle and go to IDLE.
- frame_start in any non-IDLE state aborts: FIFO is flushed, overflow is cleared, state re-arms to SKIP. No frame_done pulse is produced.
- Output FIFO:
  - 2 entries, each {ADDR_W addr, 32 data}.
  - mem_valid = !empty; mem_addr/mem_din = head entry, registered outputs.
  - Pop occurs when mem_valid && mem_ready.
  - While mem_valid && !mem_ready, mem_addr and mem_din hold stable.
  - Word becomes visible 1 cycle after the completing `ena` cycle.
- Boundary rules:
  - Push while full with a simultaneous pop: accepted, no loss.
  - Push while full without a pop: word dropped, overflow set (sticky), word_addr still increments so later addresses stay positional.
  - Pop from empty: impossible, gated by mem_valid.
- Address arithmetic: word_addr = row*words_per_row + word_in_row, implemented as a linear increment. Width ADDR_W, wraps modulo 2^ADDR_W; rows_per_frame*words_per_row must be ≤ 2^ADDR_W.
- `ena` is sampled only on CLK100MHZ edges. No clock gating inside this block.

Decomposition:
- Package edge_pkg holds:
  - WORD_W=32
  - state encoding: IDLE, SKIP, PACK, DRAIN
  - function words_per_row(px_per_row)
- Sub-module: word_fifo2, a 2-entry synchronous FIFO with push/pop/full/empty/head, parameterised on data width. Same clock and reset as this block.

Test Plan:
- Config for scenarios 1-4: px_per_row=40, rows=2, lead_px=3, mem_ready=1. Stimulus: frame_start, then 83 `ena` pulses with px = column parity. Required response:
  - first 3 pixels discarded;
  - 4 writes: addr 0..3, data 0xAAAAAAAA, 0x000000AA, 0xAAAAAAAA, 0x000000AA;
  - frame_done pulses once, 1 cycle after the addr-3 acceptance.
- Same config, mem_ready=0 through the whole frame. Required response:
  - addr 0 and 1 are held stable;
  - 3rd word is dropped and overflow=1;
  - after mem_ready=1, accepted addresses are 0,1,3, and frame_done pulses after addr 3.
- Same config, mem_ready=0 until 2 entries are queued, then released on the same cycle the 3rd word completes (simultaneous push and pop while full). Required response: no drop, overflow=0, all 4 addresses written in order.
- Abort after addr 1 is written: frame_start pulse. Required response:
  - FIFO is emptied and mem_valid=0 the next cycle;
  - SKIP again discards 3 pulses;
  - next write is addr 0;
  - no frame_done from the aborted frame.
- Assert btn_reset=0 mid-PACK, asynchronously between clock edges. Required response:
  - all outputs 0 immediately;
  - state IDLE;
  - `ena` pulses ignored until frame_start.
- Default parameters, all px=1, 520×400 frame. Required response:
  - 6800 writes (addr 0..6799);
  - word 16 of each row = 0x000000FF;
  - other words = 0xFFFFFFFF.
